// File: rtl/dmem_resp_pkg.sv
// Shared types for the data-memory responder: access-size encodings, FSM states
// and the lane helpers used by both the decode and the read-modify-write path.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        SZ_W   = 2'b00,
        SZ_H   = 2'b01,
        SZ_B   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_e;

    // Right-aligned byte mask covering the bytes touched by an access of size sz.
    function automatic logic [31:0] size_mask(input size_e sz);
        logic [31:0] m;
        case (sz)
            SZ_W:    m = 32'hFFFF_FFFF;
            SZ_H:    m = 32'h0000_FFFF;
            SZ_B:    m = 32'h0000_00FF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] lane);
        logic bad;
        case (sz)
            SZ_W:    bad = (lane != 2'b00);
            SZ_H:    bad = lane[0];
            SZ_B:    bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word store: combinational read, write-enabled synchronous write.
// Kept separate so a block RAM macro can replace it without touching the FSM.
module dmem_array #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem_q [DEPTH];

    assign rdata = mem_q[raddr];

    // NOTE: the array has no reset; contents survive reset and a reset branch
    // here would stop the store from mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// CPU data-port responder: latches one request, optionally waits, then reads or
// read-modify-writes one word and returns a single-cycle completion pulse.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic        w_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] w_data_i,
    output logic [31:0] r_data_o,
    output logic        r_valid_o,
    output logic        err_o
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ADDR_LIM  = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_e        state_q,  state_d;
    logic [AW-1:0] idx_q,    idx_d;
    logic [1:0]    lane_q,   lane_d;
    logic          w_q,      w_d;
    size_e         size_q,   size_d;
    logic [31:0]   wdata_q,  wdata_d;
    logic          err_q,    err_d;
    logic [3:0]    cnt_q,    cnt_d;
    logic [31:0]   merged_q, merged_d;
    logic [31:0]   r_data_q, r_data_d;

    logic [31:0] mem_rdata;
    logic        mem_we;
    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] acc_mask;
    logic [31:0] lane_mask;
    logic [31:0] rd_extract;
    logic [31:0] wr_merge;

    // Out-of-range addresses alias onto low words; the error check keeps them out.
    assign req_err = (addr_i >= ADDR_LIM) || misaligned(size_e'(size_i), addr_i[1:0]);

    assign shamt      = {lane_q, 3'b000};
    assign acc_mask   = size_mask(size_q);
    assign lane_mask  = acc_mask << shamt;
    assign rd_extract = (mem_rdata >> shamt) & acc_mask;
    assign wr_merge   = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

    // Storage is only ever written from the WRITE state, and never under reset.
    assign mem_we = (state_q == S_WRITE) && reset;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .raddr (idx_q),
        .rdata (mem_rdata),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (merged_q)
    );

    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        w_d      = w_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        merged_d = merged_q;
        r_data_d = r_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    idx_d   = addr_i[AW+1:2];
                    lane_d  = addr_i[1:0];
                    w_d     = w_i;
                    size_d  = size_e'(size_i);
                    wdata_d = w_data_i;
                    err_d   = req_err;
                    if (req_err) begin
                        r_data_d = '0;
                        state_d  = S_RESP;
                    end else if (WAIT > 0) begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (w_q) begin
                    merged_d = wr_merge;
                    state_d  = S_WRITE;
                end else begin
                    r_data_d = rd_extract;
                    state_d  = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its _d regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            lane_q   <= '0;
            w_q      <= 1'b0;
            size_q   <= SZ_W;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            merged_q <= '0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            w_q      <= w_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            merged_q <= merged_d;
            r_data_q <= r_data_d;
        end
    end

    // Handshake outputs are masked by reset so an abort never shows ready or a pulse.
    assign ready_o   = (state_q == S_IDLE) && reset;
    assign r_valid_o = (state_q == S_RESP) && reset;
    assign err_o     = r_valid_o && err_q;
    assign r_data_o  = r_data_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance at WAIT=0 and one at WAIT=3 share
// clock, reset and request fields; each has its own request strobe.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic [31:0] addr = '0;
    logic        w = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] wdata = '0;

    logic        ready0, valid0, err0;
    logic        ready3, valid3, err3;
    logic [31:0] rdata0, rdata3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH(512), .WAIT(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req0),
        .ready_o   (ready0),
        .addr_i    (addr),
        .w_i       (w),
        .size_i    (size),
        .w_data_i  (wdata),
        .r_data_o  (rdata0),
        .r_valid_o (valid0),
        .err_o     (err0)
    );

    dmem_resp #(.DEPTH(512), .WAIT(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req3),
        .ready_o   (ready3),
        .addr_i    (addr),
        .w_i       (w),
        .size_i    (size),
        .w_data_i  (wdata),
        .r_data_o  (rdata3),
        .r_valid_o (valid3),
        .err_o     (err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic sel_ready(input int which);
        return (which == 3) ? ready3 : ready0;
    endfunction

    function automatic logic sel_valid(input int which);
        return (which == 3) ? valid3 : valid0;
    endfunction

    function automatic logic sel_err(input int which);
        return (which == 3) ? err3 : err0;
    endfunction

    function automatic logic [31:0] sel_rdata(input int which);
        return (which == 3) ? rdata3 : rdata0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; latency counts edges from acceptance to the pulse.
    task automatic access(input int which, input string tag, input logic wr,
                          input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_data);
        int guard;
        int lat;
        guard = 0;
        while (!sel_ready(which) && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_ready"}, 32'(sel_ready(which)), 32'd1);
        addr  = a;
        w     = wr;
        size  = sz;
        wdata = wd;
        if (which == 3) req3 = 1'b1;
        else            req0 = 1'b1;
        tick();
        req0 = 1'b0;
        req3 = 1'b0;
        lat  = 1;
        while (!sel_valid(which) && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(sel_err(which)), 32'(exp_err));
        if (!wr || exp_err) begin
            check({tag, "_data"}, sel_rdata(which), exp_data);
        end
        tick();
        check({tag, "_pulse"}, 32'(sel_valid(which)), 32'd0);
        check({tag, "_ready_after"}, 32'(sel_ready(which)), 32'd1);
    endtask

    initial begin
        // Reset held for three edges, then released.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_valid0", 32'(valid0), 32'd0);
            check("rst_valid3", 32'(valid3), 32'd0);
            check("rst_ready0", 32'(ready0), 32'd0);
        end
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_err0", 32'(err0), 32'd0);
        reset = 1'b1;
        #1;
        check("rel_ready0", 32'(ready0), 32'd1);
        check("rel_ready3", 32'(ready3), 32'd1);
        check("rel_valid0", 32'(valid0), 32'd0);

        // Word write then read at WAIT=0.
        access(0, "w_wr10", 1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0);
        access(0, "w_rd10", 1'b0, SZ_W, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);

        // Byte and half-word merges; only the low bytes of the store data land.
        access(0, "b_wr12", 1'b1, SZ_B, 32'h12, 32'hFFFFFF5A, 3, 1'b0, 32'h0);
        check("hold_after_write", rdata0, 32'hDEADBEEF);
        access(0, "b_rdw10", 1'b0, SZ_W, 32'h10, 32'h0, 2, 1'b0, 32'hDE5ABEEF);
        access(0, "b_rd13", 1'b0, SZ_B, 32'h13, 32'h0, 2, 1'b0, 32'h000000DE);
        access(0, "h_rd12", 1'b0, SZ_H, 32'h12, 32'h0, 2, 1'b0, 32'h0000DE5A);
        access(0, "h_wr10", 1'b1, SZ_H, 32'h10, 32'hAAAA1234, 3, 1'b0, 32'h0);
        access(0, "h_rdw10", 1'b0, SZ_W, 32'h10, 32'h0, 2, 1'b0, 32'hDE5A1234);
        access(0, "b_rd10", 1'b0, SZ_B, 32'h10, 32'h0, 2, 1'b0, 32'h00000034);

        // Preload the words that 0x800-0x80F would alias onto, then send errors.
        access(0, "pre0", 1'b1, SZ_W, 32'h0, 32'h0BADF00D, 3, 1'b0, 32'h0);
        access(0, "pre4", 1'b1, SZ_W, 32'h4, 32'h11223344, 3, 1'b0, 32'h0);
        access(0, "pre8", 1'b1, SZ_W, 32'h8, 32'h55667788, 3, 1'b0, 32'h0);
        access(0, "preC", 1'b1, SZ_W, 32'hC, 32'h99AABBCC, 3, 1'b0, 32'h0);
        access(0, "e_h11", 1'b0, SZ_H, 32'h11, 32'h0, 1, 1'b1, 32'h0);
        access(0, "e_w802", 1'b1, SZ_W, 32'h802, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        access(0, "e_rsv", 1'b1, SZ_RSV, 32'h4, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        access(0, "e_w800", 1'b1, SZ_W, 32'h800, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        access(0, "e_b80B", 1'b1, SZ_B, 32'h80B, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        access(0, "e_rd800", 1'b0, SZ_W, 32'h800, 32'h0, 1, 1'b1, 32'h0);
        access(0, "e_rd80C", 1'b0, SZ_W, 32'h80C, 32'h0, 1, 1'b1, 32'h0);
        access(0, "keep0", 1'b0, SZ_W, 32'h0, 32'h0, 2, 1'b0, 32'h0BADF00D);
        access(0, "keep4", 1'b0, SZ_W, 32'h4, 32'h0, 2, 1'b0, 32'h11223344);
        access(0, "keep8", 1'b0, SZ_W, 32'h8, 32'h0, 2, 1'b0, 32'h55667788);
        access(0, "keepC", 1'b0, SZ_W, 32'hC, 32'h0, 2, 1'b0, 32'h99AABBCC);
        access(0, "keep_top", 1'b0, SZ_W, 32'h7FC, 32'h0, 2, 1'b1 ^ 1'b1, 32'hx);

        // WAIT=3 latencies.
        access(3, "w3_wr40", 1'b1, SZ_W, 32'h40, 32'h12345678, 6, 1'b0, 32'h0);
        access(3, "w3_rd40", 1'b0, SZ_W, 32'h40, 32'h0, 5, 1'b0, 32'h12345678);
        access(3, "w3_rdb41", 1'b0, SZ_B, 32'h41, 32'h0, 5, 1'b0, 32'h00000056);
        access(3, "w3_err", 1'b0, SZ_H, 32'h41, 32'h0, 1, 1'b1, 32'h0);

        // A write strobed while busy must be dropped, not queued.
        addr  = 32'h40;
        w     = 1'b0;
        size  = SZ_W;
        req3  = 1'b1;
        tick();
        w     = 1'b1;
        wdata = 32'hFFFFFFFF;
        check("busy_ready", 32'(ready3), 32'd0);
        tick();
        tick();
        check("busy_valid_t3", 32'(valid3), 32'd0);
        req3 = 1'b0;
        tick();
        check("busy_valid_t4", 32'(valid3), 32'd0);
        tick();
        check("busy_valid_t5", 32'(valid3), 32'd1);
        check("busy_rdata", rdata3, 32'h12345678);
        tick();
        check("busy_ready_after", 32'(ready3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_no_queue", 32'(valid3), 32'd0);
        end
        access(3, "w3_after_busy", 1'b0, SZ_W, 32'h40, 32'h0, 5, 1'b0, 32'h12345678);

        // Reset dropped during the WRITE cycle suppresses the commit and the pulse.
        access(0, "pre20", 1'b1, SZ_W, 32'h20, 32'hAAAA5555, 3, 1'b0, 32'h0);
        addr  = 32'h20;
        w     = 1'b1;
        size  = SZ_W;
        wdata = 32'h11111111;
        req0  = 1'b1;
        tick();
        req0 = 1'b0;
        check("mid_access_valid", 32'(valid0), 32'd0);
        tick();
        check("mid_write_valid", 32'(valid0), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready0), 32'd0);
        tick();
        check("mid_rst_valid", 32'(valid0), 32'd0);
        check("mid_rst_ready_hold", 32'(ready0), 32'd0);
        check("mid_rst_rdata", rdata0, 32'h0);
        reset = 1'b1;
        #1;
        check("mid_rel_ready", 32'(ready0), 32'd1);
        tick();
        check("mid_no_pulse", 32'(valid0), 32'd0);
        access(0, "keep20", 1'b0, SZ_W, 32'h20, 32'h0, 2, 1'b0, 32'hAAAA5555);
        access(0, "keep10", 1'b0, SZ_W, 32'h10, 32'h0, 2, 1'b0, 32'hDE5A1234);
        access(3, "keep40", 1'b0, SZ_W, 32'h40, 32'h0, 5, 1'b0, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 512: number of 32-bit storage words (2 kB).
REQ-002 Parameter WAIT, default 0: extra wait-state cycles inserted before each access, range 0-15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_i  input  1  request strobe from the CPU data port; accepted only when ready_o=1.
REQ-006 ready_o  output  1  responder idle and able to accept a request this cycle.
REQ-007 addr_i  input  32  byte address of the access.
REQ-008 w_i  input  1  1=write (store), 0=read (load).
REQ-009 size_i  input  2  00=word, 01=half-word, 10=byte, 11=reserved and treated as a misaligned access.
REQ-010 w_data_i  input  32  store data, right-aligned, with only the low size_i bytes meaningful.
REQ-011 r_data_o  output  32  load data, right-aligned and zero-extended.
REQ-012 r_valid_o  output  1  one-cycle completion pulse for both reads and writes.
REQ-013 err_o  output  1  error qualifier, valid only while r_valid_o=1.

Function
REQ-014 Word index SHALL be addr_i[log2(DEPTH)+1:2], and the byte lane SHALL be addr_i[1:0].
REQ-015 The access SHALL be an error if addr_i >= 4*DEPTH, if it is a half-word with addr_i[0]=1, if it is a word with addr_i[1:0]!=0, or if size_i=11.
REQ-016 FSM states SHALL be IDLE, WAIT, ACCESS, WRITE and RESP, and ready_o SHALL be 1 only in IDLE.
REQ-017 In IDLE with req_i=1, addr_i, w_i, size_i and w_data_i SHALL be latched, with the next state RESP on error, WAIT if WAIT>0, and ACCESS otherwise.
REQ-018 In WAIT, a counter loaded with WAIT-1 SHALL decrement each cycle, and the FSM SHALL go to ACCESS when the counter is 0.
REQ-019 In ACCESS, the addressed word SHALL be read; a read SHALL go to RESP with r_data_o = (word >> 8*lane) masked to the access size; a write SHALL go to WRITE with the merged word.
REQ-020 The merged word SHALL replace only the addressed lanes with the low bytes of the latched w_data_i (read-modify-write), leaving all other bytes unchanged.
REQ-021 WRITE SHALL commit the merged word to storage at the clock edge and go to RESP.
REQ-022 RESP SHALL assert r_valid_o for exactly one cycle, with err_o=1 for error accesses; the FSM SHALL then return to IDLE.
REQ-023 Error accesses SHALL never modify storage, and their r_data_o SHALL be 0.
REQ-024 With WAIT=0, a read SHALL complete with r_valid_o 2 cycles after acceptance and a write 3 cycles after acceptance; each WAIT cycle SHALL add 1 cycle to both.
REQ-025 req_i while ready_o=0 SHALL be ignored and not queued.
REQ-026 A request SHALL be acceptable in the same cycle that follows RESP, allowing back-to-back operation of one request per (latency+1) cycles.
REQ-027 r_data_o SHALL hold its value until the next read completes; only r_valid_o and err_o are pulses.

Reset
REQ-028 With reset=0 at a clock edge, the FSM SHALL go to IDLE, and r_valid_o, err_o and r_data_o SHALL be 0.
REQ-029 ready_o SHALL be 0 while reset=0 and 1 in the first cycle after release.
REQ-030 Reset asserted in any state SHALL abort the operation with no r_valid_o pulse.
REQ-031 Reset asserted in the WRITE cycle SHALL suppress the commit.
REQ-032 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-033 A shared package SHALL hold the size_i encodings (SZ_W, SZ_H, SZ_B) and the FSM state enumeration.
REQ-034 Storage SHALL be a sub-module dmem_array (DEPTH x 32, combinational read, synchronous write-enable) so it can later be swapped for a block RAM.
REQ-035 The implementation SHALL be a single clocked process for FSM and registers plus combinational lane extract/merge, totalling 120-400 lines.

Verification
REQ-036 Reset sequence: hold reset=0 for 3 cycles, then release -> ready_o=1 on the first cycle after release, and r_valid_o=0 throughout.
REQ-037 Word write then read at WAIT=0: write addr 0x10, data 0xDEADBEEF, size 00, then read addr 0x10 size 00 -> r_data_o=0xDEADBEEF, r_valid_o 2 cycles after read acceptance, err_o=0.
REQ-038 Byte merge: with word 0x10 holding 0xDEADBEEF, write byte 0x5A to addr 0x12 -> a word read returns 0xDE5ABEEF and a byte read of 0x13 returns 0x000000DE.
REQ-039 Errors: half-word read at 0x11, word write at 0x802, and a request with size 11 -> each gives r_valid_o=1 with err_o=1, and a subsequent read of 0x800-0x80F shows storage unchanged.
REQ-040 Wait states at WAIT=3: read latency is 5 cycles and write latency 6 cycles; req_i pulsed while busy is ignored, and ready_o returns the cycle after RESP.
REQ-041 Reset mid-write: drop reset in the WRITE cycle of a write of 0x11111111 to 0x20 -> the old contents of 0x20 are retained and no r_valid_o pulse occurs.
